// File: rtl/boot_loader.sv
// Framed byte-stream loader: assembles little-endian words into instruction memory
// and releases the core from reset once the payload checksum verifies.
module boot_loader #(
  parameter int unsigned MAX_WORDS      = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  localparam logic [7:0]  MAGIC      = 8'hA5;
  localparam logic [31:0] TIMEOUT_M1 = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;
  logic [31:0] idle_q, idle_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        core_reset_q, core_reset_d;
  logic        done_q, done_d;
  logic        accept;
  logic        timed;
  logic [15:0] n_words;

  assign rx_ready   = (state_q != S_DONE);
  assign accept     = rx_valid && rx_ready;
  assign timed      = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_DATA)   || (state_q == S_CHECK);
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_reset = core_reset_q;
  assign done       = done_q;
  assign error      = (state_q == S_ERROR);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    word_idx_d   = word_idx_q;
    xor_d        = xor_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    we_d         = 1'b0;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    n_words      = {rx_data, count_q[7:0]};
    // done/core_reset follow the state one cycle later
    done_d       = (state_q == S_DONE);
    core_reset_d = (state_q != S_DONE);
    idle_d       = '0;
    if (timed && !accept) idle_d = idle_q + 32'd1;

    case (state_q)
      S_IDLE, S_ERROR: begin
        if (accept && rx_data == MAGIC) begin
          state_d    = S_LEN_LO;
          word_idx_d = '0;
          xor_d      = '0;
          byte_cnt_d = '0;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_d[7:0] = rx_data;
          state_d      = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          count_d = n_words;
          if (32'(n_words) > MAX_WORDS) state_d = S_ERROR;
          else if (n_words == 16'd0)    state_d = S_CHECK;
          else                          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          xor_d      = xor_q ^ rx_data;
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            wdata_d    = {rx_data, shift_q};
            addr_d     = BASE_ADDR + {14'd0, word_idx_q, 2'b00};
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == count_q - 16'd1) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (rx_data == xor_q) ? S_DONE : S_ERROR;
      end
      S_DONE: ;
      default: state_d = S_IDLE;
    endcase

    if (timed && !accept && idle_q == TIMEOUT_M1) begin
      state_d = S_ERROR;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      word_idx_q   <= '0;
      xor_q        <= '0;
      byte_cnt_q   <= '0;
      shift_q      <= '0;
      idle_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= BASE_ADDR;
      wdata_q      <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      word_idx_q   <= word_idx_d;
      xor_q        <= xor_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      idle_q       <= idle_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: expected memory writes are queued by the stimulus
// and popped by an independent write monitor; status flags are checked directly.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;
  logic [63:0] sb_q[$];
  logic [7:0]  pay [0:7];

  boot_loader #(
    .MAX_WORDS(256),
    .BASE_ADDR(32'h0000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_valid(rx_valid),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .imem_we(imem_we),
    .imem_addr(imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .done(done),
    .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // write monitor: every strobe must match the head of the scoreboard
  always @(negedge clk) begin
    if (!reset && imem_we) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h required=none", imem_addr, imem_wdata);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        if ({imem_addr, imem_wdata} !== e) begin
          failures++;
          $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                   imem_addr, imem_wdata, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int t;
    rx_valid = 1'b0;
    if (gap > 0) begin
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (!rx_ready) check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // two-word frame; gaps vary when irregular != 0
  task automatic two_word(input logic [7:0] chk, input bit irregular);
    sb_q.push_back({32'h0000_0000, 32'h0010_0513});
    sb_q.push_back({32'h0000_0004, 32'h0020_0593});
    send(8'hA5, 0); send(8'h02, irregular ? 2 : 0); send(8'h00, 0);
    for (int i = 0; i < 8; i++) send(pay[i], irregular ? (i % 3) : 0);
    send(chk, irregular ? 3 : 0);
  endtask

  initial begin
    pay[0] = 8'h13; pay[1] = 8'h05; pay[2] = 8'h10; pay[3] = 8'h00;
    pay[4] = 8'h93; pay[5] = 8'h05; pay[6] = 8'h20; pay[7] = 8'h00;

    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_core_reset", {31'd0, core_reset}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_wdata", imem_wdata, 32'h0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);

    // good two-word load; XOR of payload is 0xB0
    two_word(8'hB0, 1'b0);
    check("ok_rx_ready", {31'd0, rx_ready}, 32'd0);
    step();
    check("ok_done", {31'd0, done}, 32'd1);
    check("ok_core_reset", {31'd0, core_reset}, 32'd0);
    check("ok_error", {31'd0, error}, 32'd0);
    check("ok_hold_addr", imem_addr, 32'h4);
    check("ok_hold_wdata", imem_wdata, 32'h0020_0593);
    check("ok_writes_drained", sb_q.size(), 32'd0);

    // bad checksum, then recovery
    do_reset();
    two_word(8'h00, 1'b0);
    check("bad_error", {31'd0, error}, 32'd1);
    step();
    check("bad_core_reset", {31'd0, core_reset}, 32'd1);
    check("bad_done", {31'd0, done}, 32'd0);
    check("bad_writes_drained", sb_q.size(), 32'd0);
    send(8'h77, 1);
    check("bad_junk_keeps_error", {31'd0, error}, 32'd1);
    two_word(8'hB0, 1'b0);
    step();
    check("recover_done", {31'd0, done}, 32'd1);
    check("recover_error", {31'd0, error}, 32'd0);
    check("recover_writes_drained", sb_q.size(), 32'd0);

    // length overflow: N = 257
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h01, 0);
    check("ovf_error", {31'd0, error}, 32'd1);
    repeat (3) step();
    check("ovf_core_reset", {31'd0, core_reset}, 32'd1);
    check("ovf_done", {31'd0, done}, 32'd0);

    // garbage then zero-length frame
    do_reset();
    send(8'h00, 0); send(8'hFF, 0);
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    step();
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_core_reset", {31'd0, core_reset}, 32'd0);

    // timeout after one payload byte
    do_reset();
    send(8'hA5, 0); send(8'h01, 0); send(8'h00, 0); send(8'h13, 0);
    repeat (15) step();
    check("to_not_yet", {31'd0, error}, 32'd0);
    step();
    check("to_error", {31'd0, error}, 32'd1);
    check("to_core_reset", {31'd0, core_reset}, 32'd1);

    // asynchronous reset after five payload bytes, then irregular full load
    do_reset();
    sb_q.push_back({32'h0000_0000, 32'h0010_0513});
    send(8'hA5, 0); send(8'h02, 0); send(8'h00, 0);
    for (int i = 0; i < 5; i++) send(pay[i], 0);
    step();
    check("mid_writes_drained", sb_q.size(), 32'd0);
    #2;
    reset = 1'b1;
    #1;
    check("async_wdata", imem_wdata, 32'h0);
    check("async_addr", imem_addr, 32'h0);
    check("async_core_reset", {31'd0, core_reset}, 32'd1);
    check("async_we", {31'd0, imem_we}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rx_ready", {31'd0, rx_ready}, 32'd1);
    two_word(8'hB0, 1'b1);
    step();
    check("irr_done", {31'd0, done}, 32'd1);
    check("irr_writes_drained", sb_q.size(), 32'd0);

    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
